// File: rtl/fir_buf_pkg.sv
// fir_buf_pkg: shared widths and FSM state types for the FIR sample burst buffer
package fir_buf_pkg;
  localparam int DATA_W = 16;
  localparam int FRAME_LEN = 64;
  localparam int IDX_W = $clog2(FRAME_LEN);
  typedef enum logic {W_FILL, W_FULL} wr_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;
endpackage

// File: rtl/fir_buf_ram.sv
// fir_buf_ram: simple dual-port {bank,idx} sample store, write port we_i/waddr_i/wdata_i, registered read port re_i/raddr_i/rdata_o
module fir_buf_ram #(
  parameter int DATA_W = 16,
  parameter int AW = 7
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [2**AW];
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/fir_sample_burst_buffer.sv
// fir_sample_burst_buffer: ping-pong frame buffer, writer in (data_in/in_write_ctrlX/able2write_out), MAC out (rd_en/rd_data/rd_valid/rd_last), status frame_ready/overflow; FIR_BUF_REVERSE_EN drains newest-first
module fir_sample_burst_buffer #(
  parameter int DATA_W = 16,
  parameter int FRAME_LEN = 64,
  parameter int IDX_W = $clog2(FRAME_LEN)
) (
  input  logic              clk1,
  input  logic              rstn,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_write_ctrlX,
  output logic              able2write_out,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              frame_ready,
  output logic              overflow
);
  import fir_buf_pkg::*;
`ifdef FIR_BUF_REVERSE_EN
  localparam logic [IDX_W-1:0] RD_FIRST = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] RD_END = '0;
  localparam logic [IDX_W-1:0] RD_STEP = '1;
`else
  localparam logic [IDX_W-1:0] RD_FIRST = '0;
  localparam logic [IDX_W-1:0] RD_END = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] RD_STEP = IDX_W'(1);
`endif
  wr_state_t wr_state_q, wr_state_d;
  rd_state_t rd_state_q, rd_state_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic able_q, ready_q, ovf_q, valid_q, last_q, seen_q;
  logic wr_acc, rd_acc, wr_end, rd_end;
  logic [DATA_W-1:0] ram_q;
  always_comb begin
    wr_acc = in_write_ctrlX && wr_state_q == W_FILL;
    rd_acc = rd_en && full_q[rd_bank_q];
    wr_end = wr_acc && wr_idx_q == IDX_W'(FRAME_LEN - 1);
    rd_end = rd_acc && rd_idx_q == RD_END;
    full_d = (full_q | (2'(wr_end) << wr_bank_q)) & ~(2'(rd_end) << rd_bank_q);
    wr_idx_d = wr_acc ? wr_idx_q + IDX_W'(1) : wr_idx_q;
    rd_idx_d = rd_acc ? rd_idx_q + RD_STEP : rd_idx_q;
    wr_bank_d = wr_bank_q ^ wr_end;
    rd_bank_d = rd_bank_q ^ rd_end;
    wr_state_d = full_d[wr_bank_d] ? W_FULL : W_FILL;
    rd_state_d = rd_end ? R_IDLE : rd_acc ? R_DRAIN : rd_state_q;
  end
  always_ff @(posedge clk1 or negedge rstn) begin
    if (!rstn) begin
      wr_state_q <= W_FILL;
      rd_state_q <= R_IDLE;
      full_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_idx_q <= '0;
      rd_idx_q <= RD_FIRST;
      able_q <= 1'b1;
      ready_q <= 1'b0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      full_q <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      able_q <= !full_d[wr_bank_d];
      ready_q <= |full_d;
      ovf_q <= ovf_q | (in_write_ctrlX && wr_state_q == W_FULL);
      valid_q <= rd_acc;
      last_q <= rd_end;
      seen_q <= seen_q | rd_acc;
    end
  end
  fir_buf_ram #(.DATA_W(DATA_W), .AW(IDX_W + 1)) u_ram (
    .clk_i(clk1),
    .we_i(wr_acc),
    .waddr_i({wr_bank_q, wr_idx_q}),
    .wdata_i(data_in),
    .re_i(rd_acc),
    .raddr_i({rd_bank_q, rd_idx_q}),
    .rdata_o(ram_q)
  );
  assign rd_data = seen_q ? ram_q : '0;
  assign rd_valid = valid_q;
  assign rd_last = last_q;
  assign able2write_out = able_q;
  assign frame_ready = ready_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_fir_sample_burst_buffer.sv
// tb_fir_sample_burst_buffer: directed checks of the ping-pong burst buffer
module tb_fir_sample_burst_buffer;
  import fir_buf_pkg::*;
  logic clk1 = 0, rstn = 0, in_write_ctrlX = 0, rd_en = 0;
  logic [15:0] data_in = '0;
  logic able2write_out, rd_valid, rd_last, frame_ready, overflow;
  logic [15:0] rd_data;
  int n_cmp = 0, n_err = 0;
  fir_sample_burst_buffer dut (
    .clk1(clk1), .rstn(rstn), .data_in(data_in), .in_write_ctrlX(in_write_ctrlX),
    .able2write_out(able2write_out), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .frame_ready(frame_ready), .overflow(overflow)
  );
  always #5 clk1 = ~clk1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [15:0] ev(input logic [15:0] b, input int k);
`ifdef FIR_BUF_REVERSE_EN
    return b + 16'(FRAME_LEN - 1 - k);
`else
    return b + 16'(k);
`endif
  endfunction
  task automatic step();
    @(posedge clk1);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
    chk({tag, "_rd_last"}, 32'(rd_last), 0);
    chk({tag, "_frame_ready"}, 32'(frame_ready), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_able2write"}, 32'(able2write_out), 1);
  endtask
  task automatic do_reset();
    rstn = 0;
    in_write_ctrlX = 0;
    rd_en = 0;
    data_in = '0;
    step();
    step();
    rstn = 1;
  endtask
  task automatic burst(input logic [15:0] base, input int n, input int gap_at, input int gap_len);
    for (int i = 0; i < n; i++) begin
      in_write_ctrlX = 1;
      data_in = base + 16'(i);
      step();
      if (i == gap_at) begin
        in_write_ctrlX = 0;
        repeat (gap_len) step();
      end
    end
    in_write_ctrlX = 0;
  endtask
  task automatic drain(input string tag, input logic [15:0] base, input bit gap);
    int k = 0;
    logic [15:0] held = '0;
    bit en;
    for (int c = 0; c < 300 && k < FRAME_LEN; c++) begin
      en = !(gap && c % 3 == 2);
      rd_en = en;
      step();
      if (en) begin
        held = ev(base, k);
        chk({tag, "_valid"}, 32'(rd_valid), 1);
        chk({tag, "_data"}, 32'(rd_data), 32'(held));
        chk({tag, "_last"}, 32'(rd_last), 32'(k == FRAME_LEN - 1));
        k++;
      end else begin
        chk({tag, "_gap_valid"}, 32'(rd_valid), 0);
        chk({tag, "_gap_hold"}, 32'(rd_data), 32'(held));
      end
    end
    rd_en = 0;
    chk({tag, "_count"}, 32'(k), FRAME_LEN);
  endtask
  initial begin
    int nl;
    do_reset();
    chk_rst("t1_reset");
    burst(16'h0001, FRAME_LEN, -1, 0);
    chk("t1_ready_after_burst", 32'(frame_ready), 1);
    chk("t1_able_one_frame", 32'(able2write_out), 1);
    drain("t1", 16'h0001, 0);
    chk("t1_ready_fall", 32'(frame_ready), 0);
    step();
    chk("t1_idle_valid", 32'(rd_valid), 0);
    chk("t1_idle_hold", 32'(rd_data), 32'(ev(16'h0001, FRAME_LEN - 1)));
    do_reset();
    burst(16'h0001, FRAME_LEN, -1, 0);
    chk("t2_able_after_64", 32'(able2write_out), 1);
    burst(16'h0101, FRAME_LEN, -1, 0);
    chk("t2_able_after_128", 32'(able2write_out), 0);
    chk("t2_ovf_before", 32'(overflow), 0);
    burst(16'h7FFF, 1, -1, 0);
    chk("t2_ovf_set", 32'(overflow), 1);
    drain("t2a", 16'h0001, 0);
    chk("t2_able_after_free", 32'(able2write_out), 1);
    drain("t2b", 16'h0101, 0);
    chk("t2_ready_end", 32'(frame_ready), 0);
    chk("t2_ovf_sticky", 32'(overflow), 1);
    do_reset();
    burst(16'h0201, FRAME_LEN, -1, 0);
    nl = 0;
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      in_write_ctrlX = i < FRAME_LEN;
      data_in = 16'h0301 + 16'(i);
      rd_en = 1;
      step();
      chk("t3_valid", 32'(rd_valid), 1);
      chk("t3_data", 32'(rd_data), 32'(i < FRAME_LEN ? ev(16'h0201, i) : ev(16'h0301, i - FRAME_LEN)));
      chk("t3_last", 32'(rd_last), 32'(i % FRAME_LEN == FRAME_LEN - 1));
      nl += int'(rd_last);
    end
    in_write_ctrlX = 0;
    rd_en = 0;
    chk("t3_last_count", 32'(nl), 2);
    chk("t3_ready_end", 32'(frame_ready), 0);
    do_reset();
    burst(16'h0501, FRAME_LEN, 19, 5);
    chk("t4_ready", 32'(frame_ready), 1);
    drain("t4", 16'h0501, 1);
    do_reset();
    burst(16'h0900, 30, -1, 0);
    rstn = 0;
    #1;
    chk_rst("t5_async_reset");
    step();
    rstn = 1;
    step();
    chk("t5_ready_discarded", 32'(frame_ready), 0);
    burst(16'h0A00, FRAME_LEN, -1, 0);
    chk("t5_ready", 32'(frame_ready), 1);
    drain("t5", 16'h0A00, 0);
    chk("t5_ready_end", 32'(frame_ready), 0);
    chk("t5_able_end", 32'(able2write_out), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_sample_burst_buffer.md
Name: fir_sample_burst_buffer

Overview:
Input-side responder for the 64-tap FIR core. It accepts 64-sample bursts from the upstream writer (write strobe plus able2write flow control) into a two-bank ping-pong store. It then presents each complete frame, in order, to the MAC datapath through a read-enable/valid interface. Frames are written and drained concurrently, so the MAC never starves while the next frame loads.

Parameters:
DATA_W, 16, sample width (signed two's complement, passed through unmodified)
FRAME_LEN, 64, samples per burst/frame (power of two)
IDX_W, $clog2(FRAME_LEN), in-frame index width

Ports:
clk1  in  1  single block clock; all logic on rising edge
rstn  in  1  asynchronous active-low reset
data_in  in  DATA_W  sample from writer
in_write_ctrlX  in  1  write strobe; data_in captured on each rising clk1 edge while high
able2write_out  out  1  high when the writer may write (current write bank not full)
rd_en  in  1  MAC requests next sample
rd_data  out  DATA_W  registered sample
rd_valid  out  1  rd_data valid this cycle
rd_last  out  1  qualifies final sample of frame (with rd_valid)
frame_ready  out  1  at least one full bank awaiting or under drain
overflow  out  1  sticky: write strobe seen while both banks full

Behaviour:
- Reset: rd_data=0, rd_valid=0, rd_last=0, frame_ready=0, overflow=0, able2write_out=1. Both banks empty; wr_bank=0, rd_bank=0, indices=0. Reset mid-burst or mid-drain discards all partial and full frames.
- Write FSM (W_FILL, W_FULL):
  - W_FILL: each strobe cycle writes data_in to {wr_bank, wr_idx} and increments wr_idx.
  - Strobe low pauses the burst; wr_idx holds; there is no timeout.
  - On the write with wr_idx=FRAME_LEN-1: set full[wr_bank], wr_idx wraps to 0, wr_bank toggles.
  - Next state is W_FULL if the new wr_bank is still full, else W_FILL.
  - W_FULL: able2write_out=0. Strobes are dropped (no memory write) and set overflow.
  - Return to W_FILL on the edge that frees wr_bank.
- able2write_out is registered, equal to !full[wr_bank] after each edge. It drops in the cycle after the last write of the second unread frame.
- Read FSM (R_IDLE, R_DRAIN):
  - R_IDLE: rd_en is ignored unless full[rd_bank]. frame_ready = full[0] | full[1], registered.
  - rd_en accepted in cycle t: rd_data/rd_valid in cycle t+1 (1-cycle latency); rd_idx increments.
  - rd_en low pauses the drain; rd_valid=0 that following cycle and rd_data holds.
  - Read of index FRAME_LEN-1: rd_last=1 with that sample. full[rd_bank] clears on the accepting edge and rd_bank toggles.
- Boundary conditions:
  - Free and fill in the same edge on different banks: both take effect; no conflict.
  - Free of bank b on the same edge as a dropped strobe: the strobe is still dropped.
  - Back-to-back frames: rd_en held high across a frame boundary continues seamlessly into the next full bank with no bubble.
  - Overflow clears only on reset.

Optional Feature:
FIR_BUF_REVERSE_EN:
- Defined: each frame is drained newest-first (index FRAME_LEN-1 down to 0). rd_last is asserted with index 0. This matches reversed coefficient ordering.
- Undefined: oldest-first (index 0 up), as above.

Decomposition:
- Package fir_buf_pkg: DATA_W, FRAME_LEN, IDX_W defaults; wr_state_t {W_FILL, W_FULL}; rd_state_t {R_IDLE, R_DRAIN}.
- Sub-module fir_buf_ram:
  - Simple dual-port, 2*FRAME_LEN x DATA_W, registered read.
  - Addressed {bank, idx}.
  - Single instance, no reset on the array.

Test Plan:
1. Reset, burst 0x0001..0x0040 continuous, then rd_en for 64 cycles -> rd_data 0x0001..0x0040 one cycle after each rd_en; rd_last only with 0x0040; frame_ready falls after the last accept.
2. Two bursts (0x0001..0x0040, 0x0101..0x0140), no reads -> able2write_out=0 after the 128th write. A further strobe with 0x7FFF sets overflow=1. Readback gives both frames intact; 0x7FFF never appears.
3. Drain frame A while writing frame B concurrently, rd_en held high 128 cycles -> 128 contiguous correct samples, no gap at the boundary, rd_last twice.
4. Burst with strobe low for 5 cycles after sample 20, and rd_en gapped every third cycle -> frame reads back as 64 correct contiguous values; rd_valid low in the gap cycles.
5. rstn asserted after 30 samples of a burst -> all outputs at reset values. A subsequent full burst of 0x0A00..0x0A3F reads back exactly those values.
6. With FIR_BUF_REVERSE_EN: burst 0x0001..0x0040 -> readback 0x0040 down to 0x0001; rd_last with 0x0001.
